// File: rtl/cart_bus_sync.sv
// Game Boy cartridge bus front end: synchronises /RD, /WR, /CS and samples A/D into the clk domain,
// producing a stable address, a one-clk write strobe and a read-request pulse. Build option: CART_BUS_WR_FILTER_EN.
module cart_bus_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int WR_MIN_CYC  = 3,
    parameter int ADR_STB_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cart_a,
    input  logic [7:0]  cart_d,
    input  logic        cart_nrd,
    input  logic        cart_nwr,
    input  logic        cart_ncs,
    output logic [15:0] adr,
    output logic [7:0]  wdata,
    output logic        write,
    output logic        rd_req,
    output logic        rd_active,
    output logic        cs,
    output logic [7:0]  drop_cnt,
    output logic [1:0]  dbg_state
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || ADR_STB_CYC < 1 || ADR_STB_CYC > 7 ||
        WR_MIN_CYC < 1 || WR_MIN_CYC > 7) begin : g_param_check
        $error("cart_bus_sync: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RD        = 2'd1,
        S_WR_LOW    = 2'd2,
        S_WR_COMMIT = 2'd3
    } state_t;

    localparam logic [2:0] STB_CYC = 3'(ADR_STB_CYC);

    state_t state;

    logic [SYNC_STAGES-1:0] nrd_sync;
    logic [SYNC_STAGES-1:0] nwr_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [15:0] a_reg;
    logic [7:0]  d_reg;
    logic [15:0] a_dly [SYNC_STAGES-1];
    logic [7:0]  d_dly [SYNC_STAGES-1];

    logic        rd_s;
    logic        wr_s;
    logic [15:0] a_al;
    logic [7:0]  d_al;
    logic [7:0]  wdata_shadow;
    logic [2:0]  stb_cnt;
    logic        conflict;
    logic        conflict_counted;
    logic        wr_runt;
    logic [7:0]  drop_next;

    // Synchronisers reset to 1 so every strobe starts inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            nrd_sync <= '1;
            nwr_sync <= '1;
            ncs_sync <= '1;
            a_reg    <= '0;
            d_reg    <= '0;
            for (int i = 0; i < SYNC_STAGES - 1; i++) begin
                a_dly[i] <= '0;
                d_dly[i] <= '0;
            end
        end else begin
            nrd_sync <= {nrd_sync[SYNC_STAGES-2:0], cart_nrd};
            nwr_sync <= {nwr_sync[SYNC_STAGES-2:0], cart_nwr};
            ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], cart_ncs};
            a_reg    <= cart_a;
            d_reg    <= cart_d;
            a_dly[0] <= a_reg;
            d_dly[0] <= d_reg;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                a_dly[i] <= a_dly[i-1];
                d_dly[i] <= d_dly[i-1];
            end
        end
    end

    assign rd_s      = ~nrd_sync[SYNC_STAGES-1];
    assign wr_s      = ~nwr_sync[SYNC_STAGES-1];
    assign cs        = ~ncs_sync[SYNC_STAGES-1];
    assign a_al      = a_dly[SYNC_STAGES-2];
    assign d_al      = d_dly[SYNC_STAGES-2];
    assign drop_next = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
    assign dbg_state = state;

`ifdef CART_BUS_WR_FILTER_EN
    localparam logic [2:0] WR_MIN = 3'(WR_MIN_CYC);
    logic [2:0] wr_cnt;

    // Holds at 1 outside WR_LOW: the cycle that entered WR_LOW already saw wr low.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= 3'd1;
        end else if (state != S_WR_LOW) begin
            wr_cnt <= 3'd1;
        end else if (wr_s && wr_cnt != 3'd7) begin
            wr_cnt <= wr_cnt + 3'd1;
        end
    end

    assign wr_runt = (wr_cnt < WR_MIN);
`else
    assign wr_runt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            adr              <= '0;
            wdata            <= '0;
            write            <= 1'b0;
            rd_req           <= 1'b0;
            rd_active        <= 1'b0;
            drop_cnt         <= '0;
            wdata_shadow     <= '0;
            stb_cnt          <= '0;
            conflict         <= 1'b0;
            conflict_counted <= 1'b0;
        end else begin
            write  <= 1'b0;
            rd_req <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    adr <= a_al;
                    if (wr_s) begin
                        state            <= S_WR_LOW;
                        wdata_shadow     <= d_al;
                        conflict         <= rd_s;
                        conflict_counted <= 1'b0;
                    end else if (rd_s) begin
                        state     <= S_RD;
                        rd_active <= 1'b1;
                        stb_cnt   <= 3'd1;
                        rd_req    <= (STB_CYC == 3'd1);
                    end
                end
                S_RD: begin
                    adr <= a_al;
                    if (wr_s) begin
                        // The conflict is counted here once; the commit only discards the write.
                        state            <= S_WR_LOW;
                        rd_active        <= 1'b0;
                        wdata_shadow     <= d_al;
                        conflict         <= 1'b1;
                        conflict_counted <= 1'b1;
                        drop_cnt         <= drop_next;
                    end else if (!rd_s) begin
                        state     <= S_IDLE;
                        rd_active <= 1'b0;
                    end else if (a_al != adr) begin
                        stb_cnt <= 3'd1;
                        rd_req  <= (STB_CYC == 3'd1);
                    end else if (stb_cnt != STB_CYC) begin
                        stb_cnt <= stb_cnt + 3'd1;
                        rd_req  <= (stb_cnt + 3'd1 == STB_CYC);
                    end
                end
                S_WR_LOW: begin
                    if (wr_s) begin
                        wdata_shadow <= d_al;
                        if (rd_s) conflict <= 1'b1;
                    end else begin
                        // Strobe is raised on entry so it is high while WR_COMMIT freezes adr.
                        state <= S_WR_COMMIT;
                        if (conflict || rd_s || wr_runt) begin
                            if (!conflict_counted) drop_cnt <= drop_next;
                        end else begin
                            write <= 1'b1;
                            wdata <= wdata_shadow;
                        end
                    end
                end
                S_WR_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bus_sync.sv
// Directed bench for cart_bus_sync: write/read latency, runt and conflict rejection, reset, drop_cnt saturation.
module tb_cart_bus_sync;

    localparam int SYNC    = 2;
    localparam int STB     = 2;
    localparam int WR_MIN  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cart_a;
    logic [7:0]  cart_d;
    logic        cart_nrd;
    logic        cart_nwr;
    logic        cart_ncs;
    logic [15:0] adr;
    logic [7:0]  wdata;
    logic        write;
    logic        rd_req;
    logic        rd_active;
    logic        cs;
    logic [7:0]  drop_cnt;
    logic [1:0]  dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wr_seen     = 0;
    int rd_seen     = 0;
    int last_wr_cyc = 0;
    int last_rd_cyc = 0;
    int rise_cyc    = 0;
    int mark_cyc    = 0;
    int base_rd     = 0;
    int base_wr     = 0;
    int base_drop   = 0;

    logic [23:0] exp_q[$];

    cart_bus_sync #(
        .SYNC_STAGES(SYNC),
        .WR_MIN_CYC (WR_MIN),
        .ADR_STB_CYC(STB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cart_a   (cart_a),
        .cart_d   (cart_d),
        .cart_nrd (cart_nrd),
        .cart_nwr (cart_nwr),
        .cart_ncs (cart_ncs),
        .adr      (adr),
        .wdata    (wdata),
        .write    (write),
        .rd_req   (rd_req),
        .rd_active(rd_active),
        .cs       (cs),
        .drop_cnt (drop_cnt),
        .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed no finish, expected finish within 1 ms");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe pops one expected {adr, wdata}
    always @(negedge clk) begin
        logic [23:0] e;
        if (write === 1'b1) begin
            wr_seen++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("write_adr", 32'(adr), 32'(e[23:8]));
                check("write_data", 32'(wdata), 32'(e[7:0]));
            end
        end
        if (rd_req === 1'b1) begin
            rd_seen++;
            last_rd_cyc = cyc;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int low,
                            input int settle, input bit commit);
        if (commit) exp_q.push_back({a, d});
        cart_a   = a;
        cart_d   = d;
        cart_nwr = 1'b0;
        tick(low);
        cart_nwr = 1'b1;
        rise_cyc = cyc;
        tick(settle);
    endtask

    task automatic do_conflict();
        cart_nrd = 1'b0;
        tick(3);
        cart_nwr = 1'b0;
        tick(2);
        cart_nrd = 1'b1;
        cart_nwr = 1'b1;
        tick(6);
    endtask

    initial begin
        reset    = 1'b1;
        cart_a   = 16'hFFFF;
        cart_d   = 8'hFF;
        cart_nrd = 1'b1;
        cart_nwr = 1'b1;
        cart_ncs = 1'b1;
        tick(3);
        check("reset_adr", 32'(adr), 32'h0);
        check("reset_wdata", 32'(wdata), 32'h0);
        check("reset_write", 32'(write), 32'h0);
        check("reset_rd_req", 32'(rd_req), 32'h0);
        check("reset_rd_active", 32'(rd_active), 32'h0);
        check("reset_cs", 32'(cs), 32'h0);
        check("reset_drop", 32'(drop_cnt), 32'h0);
        check("reset_state", 32'(dbg_state), 32'h0);
        reset  = 1'b0;
        cart_a = 16'h0000;
        cart_d = 8'h00;
        tick(5);

        // 1: plain write, latency from /WR rise
        base_wr = wr_seen;
        do_write(16'h2000, 8'h05, 8, 8, 1'b1);
        check("t1_write_count", 32'(wr_seen - base_wr), 32'd1);
        check("t1_latency", 32'(last_wr_cyc - rise_cyc), 32'(SYNC + 1));
        check("t1_wdata_hold", 32'(wdata), 32'h05);
        check("t1_pending", 32'(exp_q.size()), 32'd0);

        // 2: read with stable address
        base_rd  = rd_seen;
        base_wr  = wr_seen;
        cart_a   = 16'h4123;
        cart_nrd = 1'b0;
        mark_cyc = cyc;
        tick(5);
        check("t2_rd_active", 32'(rd_active), 32'd1);
        check("t2_adr", 32'(adr), 32'h4123);
        tick(5);
        check("t2_rd_req_count", 32'(rd_seen - base_rd), 32'd1);
        check("t2_rd_latency", 32'(last_rd_cyc - mark_cyc), 32'(SYNC + STB));
        cart_nrd = 1'b1;
        tick(5);
        check("t2_rd_inactive", 32'(rd_active), 32'd0);
        check("t2_no_write", 32'(wr_seen - base_wr), 32'd0);
        check("t2_state_idle", 32'(dbg_state), 32'h0);

        // 2b: address change mid-read re-arms rd_req
        base_rd  = rd_seen;
        cart_a   = 16'h4000;
        cart_nrd = 1'b0;
        tick(6);
        cart_a   = 16'h4001;
        mark_cyc = cyc;
        tick(6);
        check("t2b_rd_req_count", 32'(rd_seen - base_rd), 32'd2);
        check("t2b_rearm_latency", 32'(last_rd_cyc - mark_cyc), 32'(SYNC + STB));
        cart_nrd = 1'b1;
        tick(5);

        // 3: one-clk /WR pulse
        base_drop = int'(drop_cnt);
`ifdef CART_BUS_WR_FILTER_EN
        do_write(16'h0000, 8'h0A, 1, 8, 1'b0);
        check("t3_runt_drop", 32'(drop_cnt), 32'(base_drop + 1));
        do_write(16'h0010, 8'h0B, WR_MIN - 1, 8, 1'b0);
        check("t3_short_drop", 32'(drop_cnt), 32'(base_drop + 2));
        do_write(16'h0020, 8'h0C, WR_MIN, 8, 1'b1);
        check("t3_min_commit_drop", 32'(drop_cnt), 32'(base_drop + 2));
`else
        do_write(16'h0000, 8'h0A, 1, 8, 1'b1);
        check("t3_runt_wdata", 32'(wdata), 32'h0A);
        check("t3_runt_drop", 32'(drop_cnt), 32'(base_drop));
`endif
        check("t3_pending", 32'(exp_q.size()), 32'd0);

        // 4: /WR asserted during a read
        base_wr   = wr_seen;
        base_drop = int'(drop_cnt);
        cart_a    = 16'h6000;
        cart_d    = 8'h01;
        cart_nrd  = 1'b0;
        tick(4);
        cart_nwr  = 1'b0;
        tick(4);
        cart_nrd  = 1'b1;
        cart_nwr  = 1'b1;
        tick(8);
        check("t4_no_write", 32'(wr_seen - base_wr), 32'd0);
        check("t4_drop", 32'(drop_cnt), 32'(base_drop + 1));
        check("t4_state_idle", 32'(dbg_state), 32'h0);

        // 5: reset while a write is in flight
        base_wr  = wr_seen;
        cart_a   = 16'h2000;
        cart_d   = 8'h77;
        cart_nwr = 1'b0;
        tick(3);
        reset    = 1'b1;
        cart_nwr = 1'b1;
        tick(2);
        check("t5_adr", 32'(adr), 32'h0);
        check("t5_wdata", 32'(wdata), 32'h0);
        check("t5_drop", 32'(drop_cnt), 32'h0);
        check("t5_rd_active", 32'(rd_active), 32'h0);
        check("t5_state", 32'(dbg_state), 32'h0);
        reset = 1'b0;
        tick(8);
        check("t5_no_write", 32'(wr_seen - base_wr), 32'd0);
        do_write(16'h2000, 8'h03, 6, 8, 1'b1);
        check("t5_clean_write", 32'(wr_seen - base_wr), 32'd1);

        // back-to-back writes with minimum /WR high gap
        base_wr  = wr_seen;
        do_write(16'h3000, 8'h11, 4, SYNC + 1, 1'b1);
        do_write(16'h3001, 8'h22, 4, 8, 1'b1);
        check("b2b_write_count", 32'(wr_seen - base_wr), 32'd2);

        // /CS forwarding
        cart_ncs = 1'b0;
        tick(SYNC + 1);
        check("cs_active", 32'(cs), 32'd1);
        cart_ncs = 1'b1;
        tick(SYNC + 1);
        check("cs_inactive", 32'(cs), 32'd0);

        // 6: drop_cnt saturation
        base_wr = wr_seen;
        for (int i = 0; i < 300; i++) begin
`ifdef CART_BUS_WR_FILTER_EN
            do_write(16'($urandom_range(0, 16'hFFFF)), 8'($urandom_range(0, 255)), 1, 5, 1'b0);
`else
            cart_a = 16'($urandom_range(0, 16'hFFFF));
            cart_d = 8'($urandom_range(0, 255));
            do_conflict();
`endif
            if (i == 254) check("t6_reach_ff", 32'(drop_cnt), 32'hFF);
            if (i == 253) check("t6_before_ff", 32'(drop_cnt), 32'hFE);
        end
        check("t6_saturated", 32'(drop_cnt), 32'hFF);
        check("t6_no_write", 32'(wr_seen - base_wr), 32'd0);
        check("final_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
